// File: rtl/rv_branch_predictor.sv
// rv_branch_predictor: 2-bit saturating-counter branch predictor with a
// registered PC redirect on mispredict and saturating branch/mispredict
// event counters. The table is held in flops so reset can restore every
// entry in a single cycle.
module rv_branch_predictor #(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] if_pc_i,
  output logic        if_pred_taken_o,
  input  logic        ex_valid_i,
  input  logic        ex_branch_i,
  input  logic [63:0] ex_pc_i,
  input  logic [63:0] ex_target_i,
  input  logic        ex_taken_i,
  input  logic        ex_pred_taken_i,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  logic [1:0]         r_table [ENTRIES];
  logic               r_redirect;
  logic [63:0]        r_redirect_pc;
  logic [31:0]        r_br_cnt;
  logic [31:0]        r_mispred_cnt;

  logic [IDX_W-1:0]   w_if_idx;
  logic [IDX_W-1:0]   w_ex_idx;
  logic               w_res;
  logic               w_mis;
  logic [1:0]         w_ctr_old;
  logic [1:0]         w_ctr_next;
  logic [ENTRIES-1:0] w_we;
  logic               w_unused_bits;

  // Word-aligned PC bits select the counter; low two bits never matter.
  assign w_if_idx      = if_pc_i[IDX_W+1:2];
  assign w_ex_idx      = ex_pc_i[IDX_W+1:2];
  assign w_unused_bits = ^{if_pc_i[63:IDX_W+2], if_pc_i[1:0]};

  // The instruction in execute during a redirect cycle is wrong-path.
  assign w_res = ex_valid_i & ex_branch_i & ~r_redirect;
  assign w_mis = w_res & (ex_taken_i != ex_pred_taken_i);

  // Fetch reads the stored value only, so a same-cycle write is not seen.
  assign if_pred_taken_o = r_table[w_if_idx][1];

  assign w_ctr_old = r_table[w_ex_idx];

  // Saturating increment on taken, saturating decrement on not-taken.
  always_comb begin
    w_ctr_next = w_ctr_old;
    if (ex_taken_i) begin
      if (w_ctr_old != 2'b11) w_ctr_next = w_ctr_old + 2'd1;
    end else begin
      if (w_ctr_old != 2'b00) w_ctr_next = w_ctr_old - 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_we
      assign w_we[gi] = w_res & (w_ex_idx == IDX_W'(gi));
    end
  endgenerate

  // Counter table: all entries return to weak-not-taken on reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (rst_i) begin
        r_table[i] <= 2'b01;
      end else if (w_we[i]) begin
        r_table[i] <= w_ctr_next;
      end
    end
  end

  // Registered redirect: single-cycle pulse, PC held between pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= 64'd0;
    end else begin
      r_redirect <= w_mis;
      if (w_mis) begin
        r_redirect_pc <= ex_taken_i ? ex_target_i : (ex_pc_i + 64'd4);
      end
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_br_cnt      <= 32'd0;
      r_mispred_cnt <= 32'd0;
    end else begin
      if (w_res && (r_br_cnt != 32'hFFFF_FFFF)) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_mis && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign br_cnt_o      = r_br_cnt;
  assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_rv_branch_predictor.sv
// Directed testbench for rv_branch_predictor (ENTRIES = 64).
module tb_rv_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] if_pc_i;
  logic        if_pred_taken_o;
  logic        ex_valid_i;
  logic        ex_branch_i;
  logic [63:0] ex_pc_i;
  logic [63:0] ex_target_i;
  logic        ex_taken_i;
  logic        ex_pred_taken_i;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;
  logic [31:0] br_cnt_o;
  logic [31:0] mispred_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  rv_branch_predictor #(.ENTRIES(64)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .if_pc_i         (if_pc_i),
    .if_pred_taken_o (if_pred_taken_o),
    .ex_valid_i      (ex_valid_i),
    .ex_branch_i     (ex_branch_i),
    .ex_pc_i         (ex_pc_i),
    .ex_target_i     (ex_target_i),
    .ex_taken_i      (ex_taken_i),
    .ex_pred_taken_i (ex_pred_taken_i),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o),
    .br_cnt_o        (br_cnt_o),
    .mispred_cnt_o   (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] tgt,
                       input logic tk, input logic pr);
    ex_valid_i      = v;
    ex_branch_i     = 1'b1;
    ex_pc_i         = pc;
    ex_target_i     = tgt;
    ex_taken_i      = tk;
    ex_pred_taken_i = pr;
  endtask

  initial begin
    rst_i   = 1'b1;
    if_pc_i = 64'h1000;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    step();
    step();
    rst_i = 1'b0;

    // Reset state
    chk("rst_pred",   64'(if_pred_taken_o), 64'd0);
    chk("rst_redir",  64'(redirect_o),      64'd0);
    chk("rst_br",     64'(br_cnt_o),        64'd0);
    chk("rst_mis",    64'(mispred_cnt_o),   64'd0);

    // Taken mispredict at 0x1000 -> redirect to target, entry 01->10
    drive(1'b1, 64'h1000, 64'h1040, 1'b1, 1'b0);
    step();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("t_redir",    64'(redirect_o),      64'd1);
    chk("t_redir_pc", redirect_pc_o,        64'h1040);
    chk("t_br",       64'(br_cnt_o),        64'd1);
    chk("t_mis",      64'(mispred_cnt_o),   64'd1);
    chk("t_pred",     64'(if_pred_taken_o), 64'd1);
    step();
    chk("t_redir_off", 64'(redirect_o),     64'd0);

    // Not-taken mispredict at 0x2000 (same index as 0x1000): 10->01, pc+4
    if_pc_i = 64'h2000;
    drive(1'b1, 64'h2000, 64'h2100, 1'b0, 1'b1);
    step();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("nt_redir",    64'(redirect_o),      64'd1);
    chk("nt_redir_pc", redirect_pc_o,        64'h2004);
    chk("nt_pred",     64'(if_pred_taken_o), 64'd0);
    chk("nt_mis",      64'(mispred_cnt_o),   64'd2);
    step();

    // Three correct not-taken resolves: 01->00->00->00
    drive(1'b1, 64'h2000, 64'h2100, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("sat_br",      64'(br_cnt_o),        64'd5);
    chk("sat_redir",   64'(redirect_o),      64'd0);
    // A taken resolve from 00 lands on 01: still predicts not-taken
    drive(1'b1, 64'h2000, 64'h2100, 1'b1, 1'b0);
    step();
    chk("sat_pred",    64'(if_pred_taken_o), 64'd0);
    chk("sat_redir2",  64'(redirect_o),      64'd1);
    chk("sat_rpc",     redirect_pc_o,        64'h2100);
    chk("sat_mis",     64'(mispred_cnt_o),   64'd3);

    // Branch in execute during the redirect cycle is ignored
    step();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("mask_redir",  64'(redirect_o),      64'd0);
    chk("mask_br",     64'(br_cnt_o),        64'd6);
    chk("mask_mis",    64'(mispred_cnt_o),   64'd3);
    chk("mask_pred",   64'(if_pred_taken_o), 64'd0);

    // Fetch 0x1000 and execute 0x1100 share index 0: no bypass
    if_pc_i = 64'h1000;
    drive(1'b1, 64'h1100, 64'h1200, 1'b1, 1'b1);
    #1;
    chk("col_old",     64'(if_pred_taken_o), 64'd0);
    step();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("col_new",     64'(if_pred_taken_o), 64'd1);
    chk("col_redir",   64'(redirect_o),      64'd0);
    chk("col_br",      64'(br_cnt_o),        64'd7);

    // Fall-through PC wraps modulo 2^64
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 1'b1);
    step();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("wrap_redir",  64'(redirect_o),      64'd1);
    chk("wrap_rpc",    redirect_pc_o,        64'h0);
    chk("wrap_mis",    64'(mispred_cnt_o),   64'd4);
    step();

    // Branch counter saturation from a preloaded near-max value
    force dut.r_br_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_br_cnt;
    drive(1'b1, 64'h3000, 64'h3100, 1'b0, 1'b0);
    step();
    chk("brsat_1",     64'(br_cnt_o),        64'hFFFF_FFFF);
    step();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("brsat_2",     64'(br_cnt_o),        64'hFFFF_FFFF);
    chk("brsat_mis",   64'(mispred_cnt_o),   64'd4);

    // Mispredict counter saturation, leaving a redirect pending
    force dut.r_mispred_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_mispred_cnt;
    drive(1'b1, 64'h1000, 64'h1040, 1'b1, 1'b0);
    step();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("missat",      64'(mispred_cnt_o),   64'hFFFF_FFFF);
    chk("missat_redir", 64'(redirect_o),     64'd1);

    // Reset during the pending redirect
    rst_i = 1'b1;
    drive(1'b1, 64'h1000, 64'h1040, 1'b1, 1'b0);
    step();
    rst_i = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("rr_redir",    64'(redirect_o),      64'd0);
    chk("rr_br",       64'(br_cnt_o),        64'd0);
    chk("rr_mis",      64'(mispred_cnt_o),   64'd0);
    chk("rr_pred",     64'(if_pred_taken_o), 64'd0);
    // Entry back at 01: one taken resolve makes it predict taken
    drive(1'b1, 64'h1000, 64'h1040, 1'b1, 1'b1);
    step();
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("rr_train",    64'(if_pred_taken_o), 64'd1);
    chk("rr_br2",      64'(br_cnt_o),        64'd1);
    if_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    chk("rr_pred63",   64'(if_pred_taken_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
